score_ctrl: RTL
===============

Name: score_ctrl

Overview:
- Game-level sequencer for the two-digit sprite score renderer.
- Keeps the live BCD score and best score, and owns the game-phase state machine.
- Drives digit, enable and position inputs for two renderer instances (score, best), updated only at frame boundaries to prevent tearing.
- Sits between game-logic event pulses and the number renderers in the paint pipeline.

Parameters:
- PLAY_X, 16, renderer pos_x during PLAY (signed 16).
- PLAY_Y, 130, renderer pos_y during PLAY/DYING/OVER.
- OVER_X, 200, final pos_x of score sprite in OVER.
- SLIDE_STEP, 8, pos_x increment per frame while DYING.
- BEST_X, 260, fixed pos_x of best-score sprite.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- frame_start  in  1  one-cycle pulse at vblank start
- game_start  in  1  one-cycle pulse, start/restart request
- pipe_passed  in  1  one-cycle pulse, score +1
- bird_dead  in  1  one-cycle pulse, collision
- score_num0  out  4  displayed ones digit
- score_num1  out  4  displayed tens digit
- score_enable  out  1  enable for score renderer
- score_pos_x  out  16  signed, score sprite x
- score_pos_y  out  16  signed, score sprite y
- best_num0  out  4  best ones digit
- best_num1  out  4  best tens digit
- best_enable  out  1  enable for best renderer
- best_pos_x  out  16  signed, equals BEST_X
- state  out  2  IDLE=0, PLAY=1, DYING=2, OVER=3

Behaviour:
- Reset (clk, rstn synchronous active-low): state=IDLE; live and displayed score 00; best 00; score_enable=0; best_enable=0; score_pos_x=PLAY_X; score_pos_y=PLAY_Y.
- FSM transitions:
  - IDLE -game_start-> PLAY.
  - PLAY -bird_dead-> DYING.
  - DYING: on each frame_start, pos_x += SLIDE_STEP, clamped to OVER_X. Enter OVER on the frame_start where the clamped value equals OVER_X.
  - OVER -game_start-> PLAY.
  - All other events are ignored in each state.
- Entering PLAY: clear live score to 00; pos_x = PLAY_X.
- Live score:
  - Two-digit BCD, incremented on pipe_passed in PLAY only.
  - Ones wraps 9->0 with carry into tens.
  - Saturates at 99; further pulses are ignored.
  - Each pulse counts, including several within one frame.
- Same-cycle pipe_passed and bird_dead in PLAY: increment applies, then transition to DYING.
- Same-cycle game_start and frame_start: state change applies first. The frame latch captures the post-transition values (cleared score, PLAY_X).
- Display latch: on frame_start, score_num0/1 <= live digits and score_pos_x <= current position. Outputs change only in the cycle after frame_start; latency is 1 clk after frame_start.
- score_enable: 1 in PLAY, DYING and OVER; 0 in IDLE. Latched at frame_start like the digits.
- Best score: on the DYING->OVER transition, if live > best (BCD compare, tens then ones), best <= live. best_enable = (state==OVER), frame-latched.
- All outputs are registered. No combinational path from inputs to outputs.
- Reset mid-game: immediate return to the reset values, including best=00.

Optional Feature:
- Macro: SCORE_NEWBEST_BLINK_EN.
- Defined:
  - In OVER, when the last transition set a new best, best_enable toggles every 16 frames. A 4-bit frame counter is cleared on entry to OVER; best_enable is 1 for frames 0-15, 0 for frames 16-31, and so on.
  - Leaving OVER clears the new-best flag.
- Undefined: best_enable is constant 1 in OVER; no counter or flag logic is present.

Decomposition:
- Package score_pkg:
  - state enum (IDLE/PLAY/DYING/OVER, 2 bits).
  - bcd2_t struct {tens[3:0], ones[3:0]}.
  - constant BCD_MAX = 8'h99.
  - function bcd_gt(a, b).
- Sub-module bcd2_counter: clear, inc, saturate at 99. It is instantiated once, for the live score.

Test Plan:
- Reset, then 3 frame_starts -> state=0, score_enable=0, best_enable=0, digits 0/0, score_pos_x=16.
- game_start, 12 pipe_passed (2 of them in one frame), then frame_start -> state=1; num1=1, num0=2 one cycle after frame_start, not before.
- 105 pipe_passed in PLAY -> digits 9/9, no wrap.
- 7 passes, then bird_dead on the same cycle as an 8th pass -> state=2. pos_x goes 24, 32, …, 200 on successive frame_starts. At 200, state=3, best=0/8, best_enable=1.
- game_start in OVER, 5 passes, die, slide to OVER -> best stays 0/8; live score 5 displayed; pos_x reset to 16 in the frame after restart.
- With SCORE_NEWBEST_BLINK_EN: new best reached -> best_enable is 1 for 16 frames, 0 for 16 frames, and repeats. Without a new best -> best_enable is constant 1.

Source files
------------

// File: rtl/score_pkg.sv
// score_pkg: shared types and helpers for the score sequencer.
//   state_e  : game phase (IDLE/PLAY/DYING/OVER), 2-bit encoding visible on the state port
//   bcd2_t   : two-digit BCD value {tens, ones}
//   BCD_MAX  : saturation value 99
//   bcd_gt   : strict BCD greater-than, tens digit first
package score_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  localparam bcd2_t BCD_MAX = 8'h99;

  function automatic logic bcd_gt(input bcd2_t a, input bcd2_t b);
    return (a.tens > b.tens) || ((a.tens == b.tens) && (a.ones > b.ones));
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// bcd2_counter: two-digit BCD up-counter with synchronous clear, saturating at 99.
//   clk, rstn  : clock, synchronous active-low reset (count -> 00)
//   clear      : force count to 00 (wins over inc)
//   inc        : add one; ignored at 99
//   count      : registered value
//   count_next : value the register takes at the next edge, used by frame latches
//                that must capture an increment landing in the same cycle
module bcd2_counter
  import score_pkg::*;
(
  input  logic  clk,
  input  logic  rstn,
  input  logic  clear,
  input  logic  inc,
  output bcd2_t count,
  output bcd2_t count_next
);

  bcd2_t count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != BCD_MAX)) begin
      if (count_q.ones == 4'd9) begin
        count_d.ones = '0;
        count_d.tens = count_q.tens + 4'd1;
      end else begin
        count_d.ones = count_q.ones + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/score_ctrl.sv
// score_ctrl: game-phase sequencer feeding the score and best-score number renderers.
//   clk, rstn        : clock, synchronous active-low reset
//   frame_start      : vblank pulse; renderer inputs only change on the cycle after it
//   game_start       : start/restart request (IDLE or OVER -> PLAY)
//   pipe_passed      : +1 to live score while in PLAY
//   bird_dead        : PLAY -> DYING
//   score_num0/1     : displayed live score digits (frame-latched)
//   score_enable     : score renderer enable (frame-latched, off in IDLE)
//   score_pos_x/y    : score sprite position (x frame-latched, slides right while DYING)
//   best_num0/1      : best score digits
//   best_enable      : best renderer enable (frame-latched, on in OVER)
//   best_pos_x       : fixed best sprite x
//   state            : current game phase
// Optional build macro SCORE_NEWBEST_BLINK_EN: in OVER after a new best, best_enable
// alternates on/off every 16 frames.
module score_ctrl
  import score_pkg::*;
#(
  parameter logic signed [15:0] PLAY_X     = 16'sd16,
  parameter logic signed [15:0] PLAY_Y     = 16'sd130,
  parameter logic signed [15:0] OVER_X     = 16'sd200,
  parameter logic signed [15:0] SLIDE_STEP = 16'sd8,
  parameter logic signed [15:0] BEST_X     = 16'sd260
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               frame_start,
  input  logic               game_start,
  input  logic               pipe_passed,
  input  logic               bird_dead,
  output logic [3:0]         score_num0,
  output logic [3:0]         score_num1,
  output logic               score_enable,
  output logic signed [15:0] score_pos_x,
  output logic signed [15:0] score_pos_y,
  output logic [3:0]         best_num0,
  output logic [3:0]         best_num1,
  output logic               best_enable,
  output logic signed [15:0] best_pos_x,
  output logic [1:0]         state
);

  state_e             state_q, state_d;
  logic signed [15:0] pos_q, pos_d, pos_slide;
  bcd2_t              best_q, best_d;
  bcd2_t              live, live_next;
  logic               live_clr, live_inc, enter_over, new_best;

  bcd2_t              disp_q, disp_d;
  logic signed [15:0] score_pos_x_q, score_pos_x_d;
  logic               score_enable_q, score_enable_d;
  logic               best_enable_q, best_enable_d;
  logic               blink_mask;

  bcd2_counter u_live (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (live_clr),
    .inc        (live_inc),
    .count      (live),
    .count_next (live_next)
  );

  // Compare before adding so the slide cannot overflow near the clamp.
  assign pos_slide = (pos_q >= (OVER_X - SLIDE_STEP)) ? OVER_X : (pos_q + SLIDE_STEP);
  assign new_best  = bcd_gt(live, best_q);

  // Phase state machine and live position/best score.
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    best_d     = best_q;
    live_clr   = 1'b0;
    live_inc   = 1'b0;
    enter_over = 1'b0;
    unique case (state_q)
      IDLE, OVER: begin
        if (game_start) begin
          state_d  = PLAY;
          pos_d    = PLAY_X;
          live_clr = 1'b1;
        end
      end
      PLAY: begin
        // An increment in the same cycle as bird_dead still counts.
        live_inc = pipe_passed;
        if (bird_dead) state_d = DYING;
      end
      DYING: begin
        if (frame_start) begin
          pos_d = pos_slide;
          if (pos_slide == OVER_X) begin
            state_d    = OVER;
            enter_over = 1'b1;
            if (new_best) best_d = live;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame latch samples next-state values so a transition coinciding with
  // frame_start is already reflected in what the renderers see.
  always_comb begin
    disp_d         = disp_q;
    score_pos_x_d  = score_pos_x_q;
    score_enable_d = score_enable_q;
    best_enable_d  = best_enable_q;
    if (frame_start) begin
      disp_d         = live_next;
      score_pos_x_d  = pos_d;
      score_enable_d = (state_d != IDLE);
      best_enable_d  = (state_d == OVER) && !blink_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= IDLE;
      pos_q          <= PLAY_X;
      best_q         <= '0;
      disp_q         <= '0;
      score_pos_x_q  <= PLAY_X;
      score_enable_q <= 1'b0;
      best_enable_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      pos_q          <= pos_d;
      best_q         <= best_d;
      disp_q         <= disp_d;
      score_pos_x_q  <= score_pos_x_d;
      score_enable_q <= score_enable_d;
      best_enable_q  <= best_enable_d;
    end
  end

`ifdef SCORE_NEWBEST_BLINK_EN
  logic       newbest_q, newbest_d;
  logic       blink_off_q, blink_off_d;
  logic [3:0] blink_cnt_q, blink_cnt_d;

  // The entry frame is frame 0; the off phase flips each time the 4-bit count wraps.
  always_comb begin
    newbest_d   = newbest_q;
    blink_off_d = blink_off_q;
    blink_cnt_d = blink_cnt_q;
    if (enter_over) begin
      newbest_d   = new_best;
      blink_off_d = 1'b0;
      blink_cnt_d = '0;
    end else if (state_q == OVER) begin
      if (state_d != OVER) begin
        newbest_d = 1'b0;
      end else if (frame_start) begin
        blink_cnt_d = blink_cnt_q + 4'd1;
        if (blink_cnt_q == 4'hf) blink_off_d = ~blink_off_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      newbest_q   <= 1'b0;
      blink_off_q <= 1'b0;
      blink_cnt_q <= '0;
    end else begin
      newbest_q   <= newbest_d;
      blink_off_q <= blink_off_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign blink_mask = newbest_d & blink_off_d;
`else
  assign blink_mask = 1'b0;
`endif

  assign score_num0   = disp_q.ones;
  assign score_num1   = disp_q.tens;
  assign score_enable = score_enable_q;
  assign score_pos_x  = score_pos_x_q;
  assign score_pos_y  = PLAY_Y;
  assign best_num0    = best_q.ones;
  assign best_num1    = best_q.tens;
  assign best_enable  = best_enable_q;
  assign best_pos_x   = BEST_X;
  assign state        = state_q;

endmodule
